// File: rtl/cic_intp.sv
// CIC interpolator: comb section at the input rate, zero-stuffing by rate, pipelined integrators, saturating output.
// Latency: first cke_out appears stages+3 cycles after the cke that carried the sample.
// Backpressure: none; a cke arriving mid-burst restarts the burst and sets the sticky overrun flag.
module cic_intp #(
    parameter int rate      = 5,
    parameter int stages    = 3,
    parameter int out_shift = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        cke_out,
    output logic        overrun
);

    // Bit growth of the full structure is stages*ceil(log2(rate)) above the 16-bit input.
    localparam int LOG2R = $clog2(rate);
    localparam int W     = 16 + stages * LOG2R;
    localparam int PW    = LOG2R;

    localparam logic [PW-1:0]       PH_LAST = PW'(rate - 1);
    localparam logic signed [W-1:0] SAT_MAX = {{(W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(W-15){1'b1}}, {15{1'b0}}};

    // Comb section state
    logic signed [W-1:0] dly_q  [stages];
    logic signed [W-1:0] dly_d  [stages];
    logic signed [W-1:0] comb_q;
    logic signed [W-1:0] comb_d;

    // Burst control
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          busy_q;
    logic          busy_d;
    logic          overrun_q;
    logic          overrun_d;

    // Integrator pipeline; ivld_q[k] marks that integ_q[k] took a step last cycle
    logic signed [W-1:0] integ_q [stages];
    logic signed [W-1:0] integ_d [stages];
    logic [stages-1:0]   ivld_q;
    logic [stages-1:0]   ivld_d;
    logic signed [W-1:0] stuffed;

    // Output stages: saturate first, then present value and strobe together
    logic signed [W-1:0] shifted;
    logic [15:0]         sat_q;
    logic [15:0]         sat_d;
    logic                svld_q;
    logic                svld_d;
    logic [15:0]         dout_q;
    logic [15:0]         dout_d;
    logic                cke_out_q;
    logic                cke_out_d;

    // Comb chain: each stage subtracts its delayed input; everything advances only on cke
    always_comb begin : comb_sec
        logic signed [W-1:0] acc;
        acc = {{(W-16){din[15]}}, din};
        for (int k = 0; k < stages; k++) begin
            dly_d[k] = cke ? acc : dly_q[k];
            acc      = acc - dly_q[k];
        end
        comb_d = cke ? acc : comb_q;
    end

    // Phase counter and sticky overrun: cke always restarts at phase 0, late phase drop is flagged
    always_comb begin
        phase_d   = phase_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        if (cke) begin
            phase_d = '0;
            busy_d  = 1'b1;
            if (busy_q && (phase_q != PH_LAST)) begin
                overrun_d = 1'b1;
            end
        end else if (busy_q) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                busy_d  = 1'b0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    // Zero-stuffed integrator input: the comb result only at phase 0 of a burst
    always_comb begin
        stuffed = '0;
        if (busy_q && (phase_q == '0)) begin
            stuffed = comb_q;
        end
    end

    // Integrators: stage k steps one cycle after stage k-1, using its registered value; wrap is intended
    always_comb begin
        integ_d[0] = busy_q ? (integ_q[0] + stuffed) : integ_q[0];
        ivld_d[0]  = busy_q;
        for (int k = 1; k < stages; k++) begin
            integ_d[k] = ivld_q[k-1] ? (integ_q[k] + integ_q[k-1]) : integ_q[k];
            ivld_d[k]  = ivld_q[k-1];
        end
    end

    // Scale and clamp the last integrator into 16 bits, then publish value and strobe in the same cycle
    always_comb begin
        shifted   = integ_q[stages-1] >>> out_shift;
        sat_d     = sat_q;
        svld_d    = ivld_q[stages-1];
        dout_d    = dout_q;
        cke_out_d = svld_q;
        if (ivld_q[stages-1]) begin
            if (shifted > SAT_MAX) begin
                sat_d = 16'h7fff;
            end else if (shifted < SAT_MIN) begin
                sat_d = 16'h8000;
            end else begin
                sat_d = shifted[15:0];
            end
        end
        if (svld_q) begin
            dout_d = sat_q;
        end
    end

    // State registers, all cleared asynchronously so a reset aborts any burst in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < stages; k++) begin
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
            comb_q    <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            ivld_q    <= '0;
            sat_q     <= '0;
            svld_q    <= 1'b0;
            dout_q    <= '0;
            cke_out_q <= 1'b0;
        end else begin
            for (int k = 0; k < stages; k++) begin
                dly_q[k]   <= dly_d[k];
                integ_q[k] <= integ_d[k];
            end
            comb_q    <= comb_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            ivld_q    <= ivld_d;
            sat_q     <= sat_d;
            svld_q    <= svld_d;
            dout_q    <= dout_d;
            cke_out_q <= cke_out_d;
        end
    end

    assign dout    = dout_q;
    assign cke_out = cke_out_q;
    assign overrun = overrun_q;

endmodule

// File: doc/cic_intp.md
CIC_INTP -- requirements
Module: cic_intp

Interface
REQ-001 Parameter: rate, default 5, interpolation factor, range 2..16.
REQ-002 Parameter: stages, default 3, number of comb stages and number of integrator stages, range 1..5.
REQ-003 Parameter: out_shift, default 5, arithmetic right shift applied before output saturation.
REQ-004 Port: clk  input  1  sole clock.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: cke  input  1  low-rate input sample strobe, one-cycle pulse.
REQ-007 Port: din  input  16  signed input sample, valid when cke=1.
REQ-008 Port: dout  output  16  signed interpolated output sample.
REQ-009 Port: cke_out  output  1  one-cycle pulse marking each new dout value.
REQ-010 Port: overrun  output  1  sticky flag, set when cke arrives before the current output burst completes.

Function
REQ-011 Internal width shall be W = 16 + stages*ceil(log2(rate)) bits, two's complement; integrator wrap-around is permitted and required (no saturation inside the CIC).
REQ-012 Comb section: on each cke, stage 1 input is din sign-extended to W; stage k shall compute x_k - d_k; every d_k <= x_k; the comb result is registered into comb_q in the same cycle; combs are idle when cke=0.
REQ-013 Phase counter: 0..rate-1; it shall load 0 and set busy the cycle after cke, advance once per clk while busy, and clear busy after phase rate-1.
REQ-014 Zero-stuffing: integrator input = comb_q at phase 0, 0 at phases 1..rate-1.
REQ-015 Integrators: pipelined and updated only on busy cycles; I_1 <= I_1 + stuffed input; I_k <= I_k + I_(k-1) (old value).
REQ-016 Output: on each busy cycle, dout <= saturate16(I_stages >>> out_shift), clamped to [-32768, 32767]; cke_out=1 in the cycle after that update; dout holds between updates.
REQ-017 DC gain shall be rate^(stages-1) / 2^out_shift; each input sample produces exactly rate cke_out pulses.
REQ-018 Latency: first cke_out for a given cke shall occur a fixed number of cycles after it, equal to stages+3 for the pipelined structure; the bench shall measure and lock this value.
REQ-019 cke spacing >= rate cycles is normal operation; cke while busy with phase < rate-1 shall restart the phase counter at 0 with the new sample, drop the remaining phases of the old burst, and set overrun.
REQ-020 cke coinciding with phase rate-1 shall not be an overrun; the burst shall continue seamlessly.
REQ-021 overrun shall clear only on reset.
REQ-022 cke=1 for consecutive cycles shall be treated as repeated samples, each restarting the burst per REQ-019.

Reset
REQ-023 On rst=1, asynchronously clear all comb delays, comb_q, integrators, phase counter, busy, dout, cke_out and overrun to 0.
REQ-024 Reset mid-burst shall abort the burst with no further cke_out; after release, the first cke shall behave identically to the first cke after power-up.

Verification
REQ-025 Impulse: default params with out_shift=0; din=1 at one cke, then din=0 at cke every 5 cycles -> 13 consecutive dout values 1,3,6,10,15,18,19,18,15,10,6,3,1, then 0.
REQ-026 DC: defaults; din=1000 at cke every 5 cycles -> steady dout=781 (25000>>>5) on every cke_out; overrun stays 0.
REQ-027 Saturation: out_shift=0; din=32767 constant -> dout clamps at 32767; din=-32768 constant -> dout clamps at -32768; no wrap visible at dout.
REQ-028 Overrun: cke pulses 2 cycles apart -> overrun=1 on the cycle after the second cke; burst restarts; overrun stays 1 until rst.
REQ-029 Reset mid-burst: assert rst at phase 2 of a DC burst -> dout=0, cke_out=0 immediately; after release, repeat REQ-025 -> identical sequence and latency.
REQ-030 Count check: N cke pulses at the legal spacing -> exactly 5N cke_out pulses; cke exactly at phase rate-1 -> no overrun.
